// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  // Active-low row drive, indexed by row_idx.
  localparam logic [3:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Index of the lowest active-low column; only meaningful when any bit is low.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for the active-low column lines; idles high.
module sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 4'hf;
      q    <= 4'hf;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// Row-scanning 4x4 keypad decoder with press/release debounce and an
// eight-deep code history for the display.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV_W   = 17,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  input  logic        key_ack,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        overrun,
  output logic [31:0] key_buf
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]            col_s;
  logic [SCAN_DIV_W-1:0] div;
  logic                  tick;
  state_t                state;
  logic [1:0]            row_idx;
  logic [1:0]            col_idx;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         rel_cnt;
  logic                  any_low;
  logic [1:0]            low;
  logic                  accept;
  logic [3:0]            code;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col),
    .q     (col_s)
  );

  // Tick fires on the cycle the prescaler wraps back to zero.
  assign tick    = &div;
  assign any_low = ~&col_s;
  assign low     = low_col(col_s);
  assign code    = {row_idx, col_idx};
  assign accept  = tick && (state == DEBOUNCE) && any_low && (low == col_idx)
                   && (cnt == CW'(DEBOUNCE_CNT - 1));
  assign row     = ROW_DRIVE[row_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      div       <= '0;
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      cnt       <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      key_buf   <= 32'h0;
    end else begin
      div <= div + SCAN_DIV_W'(1);

      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              col_idx <= low;
              cnt     <= CW'(1);
              state   <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (any_low && low == col_idx) begin
              cnt <= cnt + CW'(1);
              if (accept) begin
                rel_cnt <= '0;
                state   <= PRESSED;
              end
            end else begin
              cnt     <= '0;
              row_idx <= row_idx + 2'd1;
              state   <= SCAN;
            end
          end
          PRESSED: begin
            if (any_low) begin
              rel_cnt <= '0;
            end else if (rel_cnt == CW'(DEBOUNCE_CNT - 1)) begin
              rel_cnt <= '0;
              cnt     <= '0;
              row_idx <= row_idx + 2'd1;
              state   <= SCAN;
            end else begin
              rel_cnt <= rel_cnt + CW'(1);
            end
          end
          default: state <= SCAN;
        endcase
      end

      // A same-cycle ack cannot clear a fresh key; it only suppresses overrun.
      if (accept) begin
        key_code  <= code;
        key_buf   <= {key_buf[27:0], code};
        key_valid <= 1'b1;
        if (key_valid && !key_ack) overrun <= 1'b1;
      end else if (key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end
endmodule
